pipe_ctrl_unit: RTL and testbench
=================================

// Module: pipe_ctrl_unit
// PURPOSE
//  Parametrised main decoder, ALU decoder and D->E->M->W control pipeline for the 5-stage MIPS core.
//  Decodes instrD and computes the destination register number, carrying both down the pipeline.
//  Per-stage stall/flush, automatic bubble insertion under stall, and bne support.
//  Resolves the branch in M (pcsrcM). Feeds datapath muxes and the hazard unit (wreg*, regwrite*).
// PARAMETERS
//  ALUCTRL_W  4   alucontrol width; >=4, codes zero-extended to this width
//  LINK_REG   31  register written by jal
// PORTS
//  clk          in   1          rising-edge clock
//  rst          in   1          asynchronous, active-high reset
//  instrD       in   32         instruction in Decode
//  stallE       in   1          hold D/E register
//  flushE       in   1          clear D/E register (bubble)
//  stallM       in   1          hold E/M register
//  flushM       in   1          clear E/M register
//  zeroM        in   1          ALU zero flag, registered into M by datapath
//  jumpD        out  1          j/jal/jr/jalr in D
//  jump_regD    out  1          target from rs (jr/jalr)
//  branchD      out  1          beq/bne in D
//  alusrcE      out  1          1: immediate operand
//  zero_extE    out  1          1: zero-extend immediate (andi/ori/xori)
//  alucontrolE  out  ALUCTRL_W  ALU operation
//  regwriteE/M/W out 1          register-file write enable per stage
//  memtoregE/M/W out 1          writeback from memory
//  memwriteM    out  1          data-memory write
//  linkM/W      out  1          writeback value is pc+8
//  wregE/M/W    out  5          destination register number
//  pcsrcM       out  1          take branch
//  illegalM     out  1          illegal instruction reached M (feature-gated)
// BEHAVIOUR
//  Decode (comb): lw, sw, beq, bne, addi, addiu, andi, ori, xori, slti, lui, j, jal;
//   R-type add, addu, sub, subu, and, or, xor, nor, slt, jr, jalr.
//  ALU codes: AND 0000, OR 0001, ADD 0010, XOR 0011, NOR 0100, LUI 0101, SUB 0110, SLT 0111.
//  lw/sw/addi/addiu -> ADD; beq/bne -> SUB.
//  wreg: jal -> LINK_REG; R-type/jalr -> rd; I-type -> rt.
//  Non-writing instructions (sw, beq, bne, j, jr) carry wreg=0.
//  jr: regwrite=0. jalr: regwrite=1, link=1, writes rd. jal: regwrite=1, link=1.
//  Writes to r0 keep regwrite as decoded; the register file ignores r0.
//  Stage registers: D/E, E/M, M/W.
//   D/E: flushE -> all zero; else stallE -> hold; else load decode.
//   E/M: flushM -> all zero; else stallM -> hold.
//        Else stallE=1 -> load bubble (all zero), so the stalled E instruction is not duplicated.
//        Else load E.
//   M/W: stallM=1 -> load bubble; else load M. No W stall.
//  Flush beats stall in the same cycle. Latency: D->E->M->W one cycle each.
//  pcsrcM = branchM & (zeroM ^ bneM); combinational from M-stage state.
//  Bubble = all-zero vector: regwrite=0, memwrite=0, branch=0, wreg=0.
//  Reset: every registered output and every stage bit 0 immediately, independent of clk.
//   Comb D outputs follow instrD.
//  Reset mid-stall: contents discarded; pipeline restarts empty.
// CONFIGURATION
//  CTRL_ILLEGAL_EN defined:
//   Unknown opcode/funct sets illegal bit in D, carried through E and M.
//   In that instruction: regwrite=memwrite=branch=jump=0.
//   illegalM=1 for each cycle the instruction occupies M.
//  CTRL_ILLEGAL_EN undefined:
//   Unknown encodings decode to an all-zero control vector; illegalM tied 0; no illegal flop.
// TESTING
//  1. add $3,$1,$2 (0x00221820), no stalls
//     -> E: alucontrolE=0010, wregE=3; W: regwriteW=1, wregW=3 three edges after D.
//  2. bne, zeroM=0 in M -> pcsrcM=1; beq, zeroM=0 -> pcsrcM=0; beq, zeroM=1 -> pcsrcM=1.
//  3. lw $4 then stallE=1 for one cycle
//     -> lw held in E; M receives bubble (regwriteM=0, wregM=0); lw reaches W once.
//  4. flushE=1 and stallE=1 together with sw in D -> regwriteE=0, memwriteM=0 next cycle.
//  5. jal -> wregW=31, linkW=1.
//     jalr $5 -> wregW=5, linkW=1, jump_regD=1.
//     jr -> regwriteW=0.
//  6. rst asserted mid-stream between edges -> all stage outputs 0 at once.
//     With CTRL_ILLEGAL_EN, opcode 0x3F -> illegalM=1, memwriteM=0.

Source files
------------

// File: rtl/pipe_ctrl_unit.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_ctrl_unit
//  Purpose  : Main decoder, ALU decoder and D->E->M->W control pipeline for
//             the 5-stage MIPS core. Decodes instrD, picks the destination
//             register, carries the control word down the pipe with per-stage
//             stall/flush and bubble insertion, and resolves beq/bne in M.
//  Ports    : clk, rst (async, active high)
//             instrD                     - instruction in Decode
//             stallE/flushE              - hold / clear D/E register
//             stallM/flushM              - hold / clear E/M register
//             zeroM                      - ALU zero flag of the M instruction
//             jumpD, jump_regD, branchD  - combinational Decode outputs
//             alusrcE, zero_extE, alucontrolE, regwriteE, memtoregE, wregE
//             regwriteM, memtoregM, memwriteM, linkM, wregM, pcsrcM, illegalM
//             regwriteW, memtoregW, linkW, wregW
//  Config   : CTRL_ILLEGAL_EN - when defined, unknown encodings carry an
//             illegal bit through E and M (illegalM); otherwise they decode
//             to an all-zero control word and illegalM is tied low.
//  Revision : 1.0 - initial release
// ============================================================================
module pipe_ctrl_unit #(
    parameter int          ALUCTRL_W = 4,
    parameter int unsigned LINK_REG  = 31
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [31:0]          instrD,
    input  logic                 stallE,
    input  logic                 flushE,
    input  logic                 stallM,
    input  logic                 flushM,
    input  logic                 zeroM,
    output logic                 jumpD,
    output logic                 jump_regD,
    output logic                 branchD,
    output logic                 alusrcE,
    output logic                 zero_extE,
    output logic [ALUCTRL_W-1:0] alucontrolE,
    output logic                 regwriteE,
    output logic                 regwriteM,
    output logic                 regwriteW,
    output logic                 memtoregE,
    output logic                 memtoregM,
    output logic                 memtoregW,
    output logic                 memwriteM,
    output logic                 linkM,
    output logic                 linkW,
    output logic [4:0]           wregE,
    output logic [4:0]           wregM,
    output logic [4:0]           wregW,
    output logic                 pcsrcM,
    output logic                 illegalM
);

    // ------------------------------------------------------------------
    // Encodings
    // ------------------------------------------------------------------
    localparam logic [4:0] C_LINK_REG = LINK_REG[4:0];

    localparam logic [5:0] C_OP_RTYPE = 6'h00;
    localparam logic [5:0] C_OP_J     = 6'h02;
    localparam logic [5:0] C_OP_JAL   = 6'h03;
    localparam logic [5:0] C_OP_BEQ   = 6'h04;
    localparam logic [5:0] C_OP_BNE   = 6'h05;
    localparam logic [5:0] C_OP_ADDI  = 6'h08;
    localparam logic [5:0] C_OP_ADDIU = 6'h09;
    localparam logic [5:0] C_OP_SLTI  = 6'h0A;
    localparam logic [5:0] C_OP_ANDI  = 6'h0C;
    localparam logic [5:0] C_OP_ORI   = 6'h0D;
    localparam logic [5:0] C_OP_XORI  = 6'h0E;
    localparam logic [5:0] C_OP_LUI   = 6'h0F;
    localparam logic [5:0] C_OP_LW    = 6'h23;
    localparam logic [5:0] C_OP_SW    = 6'h2B;

    localparam logic [5:0] C_FN_JR    = 6'h08;
    localparam logic [5:0] C_FN_JALR  = 6'h09;
    localparam logic [5:0] C_FN_ADD   = 6'h20;
    localparam logic [5:0] C_FN_ADDU  = 6'h21;
    localparam logic [5:0] C_FN_SUB   = 6'h22;
    localparam logic [5:0] C_FN_SUBU  = 6'h23;
    localparam logic [5:0] C_FN_AND   = 6'h24;
    localparam logic [5:0] C_FN_OR    = 6'h25;
    localparam logic [5:0] C_FN_XOR   = 6'h26;
    localparam logic [5:0] C_FN_NOR   = 6'h27;
    localparam logic [5:0] C_FN_SLT   = 6'h2A;

    localparam logic [3:0] C_ALU_AND  = 4'b0000;
    localparam logic [3:0] C_ALU_OR   = 4'b0001;
    localparam logic [3:0] C_ALU_ADD  = 4'b0010;
    localparam logic [3:0] C_ALU_XOR  = 4'b0011;
    localparam logic [3:0] C_ALU_NOR  = 4'b0100;
    localparam logic [3:0] C_ALU_LUI  = 4'b0101;
    localparam logic [3:0] C_ALU_SUB  = 4'b0110;
    localparam logic [3:0] C_ALU_SLT  = 4'b0111;

    // ------------------------------------------------------------------
    // Control words per stage. Each stage keeps only what it or a later
    // stage consumes; an all-zero word is a bubble.
    // ------------------------------------------------------------------
    typedef struct packed {
        logic       regwrite;
        logic       memtoreg;
        logic       memwrite;
        logic       branch;
        logic       bne;
        logic       alusrc;
        logic       zero_ext;
        logic       link;
        logic [3:0] alu;
        logic [4:0] wreg;
    } e_ctrl_t;

    typedef struct packed {
        logic       regwrite;
        logic       memtoreg;
        logic       memwrite;
        logic       branch;
        logic       bne;
        logic       link;
        logic [4:0] wreg;
    } m_ctrl_t;

    typedef struct packed {
        logic       regwrite;
        logic       memtoreg;
        logic       link;
        logic [4:0] wreg;
    } w_ctrl_t;

    logic [5:0] w_op;
    logic [5:0] w_funct;
    logic [4:0] w_rt;
    logic [4:0] w_rd;
    e_ctrl_t    w_dec;
    logic       w_jump;
    logic       w_jump_reg;
    logic       w_illegal;
    m_ctrl_t    w_e_to_m;
    w_ctrl_t    w_m_to_w;

    e_ctrl_t    r_e;
    m_ctrl_t    r_m;
    w_ctrl_t    r_w;

    assign w_op    = instrD[31:26];
    assign w_funct = instrD[5:0];
    assign w_rt    = instrD[20:16];
    assign w_rd    = instrD[15:11];

    // rs and shamt are datapath concerns; the illegal flag is only stored
    // when the illegal-instruction feature is built in.
    logic w_unused;
    assign w_unused = ^{w_illegal, instrD[25:21], instrD[10:6]};

    // ------------------------------------------------------------------
    // Main + ALU decoder. Anything not matched leaves the word at zero
    // and raises w_illegal. Jumps carry ALU code 0000 (unused by datapath).
    // ------------------------------------------------------------------
    always_comb begin
        w_dec      = '0;
        w_jump     = 1'b0;
        w_jump_reg = 1'b0;
        w_illegal  = 1'b0;
        case (w_op)
            C_OP_RTYPE: begin
                case (w_funct)
                    C_FN_ADD, C_FN_ADDU: begin
                        w_dec.regwrite = 1'b1;
                        w_dec.alu      = C_ALU_ADD;
                        w_dec.wreg     = w_rd;
                    end
                    C_FN_SUB, C_FN_SUBU: begin
                        w_dec.regwrite = 1'b1;
                        w_dec.alu      = C_ALU_SUB;
                        w_dec.wreg     = w_rd;
                    end
                    C_FN_AND: begin
                        w_dec.regwrite = 1'b1;
                        w_dec.alu      = C_ALU_AND;
                        w_dec.wreg     = w_rd;
                    end
                    C_FN_OR: begin
                        w_dec.regwrite = 1'b1;
                        w_dec.alu      = C_ALU_OR;
                        w_dec.wreg     = w_rd;
                    end
                    C_FN_XOR: begin
                        w_dec.regwrite = 1'b1;
                        w_dec.alu      = C_ALU_XOR;
                        w_dec.wreg     = w_rd;
                    end
                    C_FN_NOR: begin
                        w_dec.regwrite = 1'b1;
                        w_dec.alu      = C_ALU_NOR;
                        w_dec.wreg     = w_rd;
                    end
                    C_FN_SLT: begin
                        w_dec.regwrite = 1'b1;
                        w_dec.alu      = C_ALU_SLT;
                        w_dec.wreg     = w_rd;
                    end
                    C_FN_JR: begin
                        w_jump     = 1'b1;
                        w_jump_reg = 1'b1;
                    end
                    C_FN_JALR: begin
                        w_jump         = 1'b1;
                        w_jump_reg     = 1'b1;
                        w_dec.regwrite = 1'b1;
                        w_dec.link     = 1'b1;
                        w_dec.wreg     = w_rd;
                    end
                    default: w_illegal = 1'b1;
                endcase
            end
            C_OP_LW: begin
                w_dec.regwrite = 1'b1;
                w_dec.memtoreg = 1'b1;
                w_dec.alusrc   = 1'b1;
                w_dec.alu      = C_ALU_ADD;
                w_dec.wreg     = w_rt;
            end
            C_OP_SW: begin
                w_dec.memwrite = 1'b1;
                w_dec.alusrc   = 1'b1;
                w_dec.alu      = C_ALU_ADD;
            end
            C_OP_BEQ: begin
                w_dec.branch = 1'b1;
                w_dec.alu    = C_ALU_SUB;
            end
            C_OP_BNE: begin
                w_dec.branch = 1'b1;
                w_dec.bne    = 1'b1;
                w_dec.alu    = C_ALU_SUB;
            end
            C_OP_ADDI, C_OP_ADDIU: begin
                w_dec.regwrite = 1'b1;
                w_dec.alusrc   = 1'b1;
                w_dec.alu      = C_ALU_ADD;
                w_dec.wreg     = w_rt;
            end
            C_OP_ANDI: begin
                w_dec.regwrite = 1'b1;
                w_dec.alusrc   = 1'b1;
                w_dec.zero_ext = 1'b1;
                w_dec.alu      = C_ALU_AND;
                w_dec.wreg     = w_rt;
            end
            C_OP_ORI: begin
                w_dec.regwrite = 1'b1;
                w_dec.alusrc   = 1'b1;
                w_dec.zero_ext = 1'b1;
                w_dec.alu      = C_ALU_OR;
                w_dec.wreg     = w_rt;
            end
            C_OP_XORI: begin
                w_dec.regwrite = 1'b1;
                w_dec.alusrc   = 1'b1;
                w_dec.zero_ext = 1'b1;
                w_dec.alu      = C_ALU_XOR;
                w_dec.wreg     = w_rt;
            end
            C_OP_SLTI: begin
                w_dec.regwrite = 1'b1;
                w_dec.alusrc   = 1'b1;
                w_dec.alu      = C_ALU_SLT;
                w_dec.wreg     = w_rt;
            end
            C_OP_LUI: begin
                w_dec.regwrite = 1'b1;
                w_dec.alusrc   = 1'b1;
                w_dec.alu      = C_ALU_LUI;
                w_dec.wreg     = w_rt;
            end
            C_OP_J: begin
                w_jump = 1'b1;
            end
            C_OP_JAL: begin
                w_jump         = 1'b1;
                w_dec.regwrite = 1'b1;
                w_dec.link     = 1'b1;
                w_dec.wreg     = C_LINK_REG;
            end
            default: w_illegal = 1'b1;
        endcase
    end

    assign jumpD     = w_jump;
    assign jump_regD = w_jump_reg;
    assign branchD   = w_dec.branch;

    // ------------------------------------------------------------------
    // D/E register: flush wins over stall.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_e <= '0;
        end else if (flushE) begin
            r_e <= '0;
        end else if (!stallE) begin
            r_e <= w_dec;
        end
    end

    assign w_e_to_m = '{regwrite: r_e.regwrite, memtoreg: r_e.memtoreg,
                        memwrite: r_e.memwrite, branch:   r_e.branch,
                        bne:      r_e.bne,      link:     r_e.link,
                        wreg:     r_e.wreg};

    // ------------------------------------------------------------------
    // E/M register. While E is stalled but M is free to advance, M takes
    // a bubble so the held E instruction is not issued twice.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_m <= '0;
        end else if (flushM) begin
            r_m <= '0;
        end else if (!stallM) begin
            r_m <= stallE ? '0 : w_e_to_m;
        end
    end

    assign w_m_to_w = '{regwrite: r_m.regwrite, memtoreg: r_m.memtoreg,
                        link:     r_m.link,     wreg:     r_m.wreg};

    // ------------------------------------------------------------------
    // M/W register: W never stalls, so a held M instruction is followed
    // by a bubble in W.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_w <= '0;
        end else begin
            r_w <= stallM ? '0 : w_m_to_w;
        end
    end

    // ------------------------------------------------------------------
    // Illegal-instruction tracking
    // ------------------------------------------------------------------
`ifdef CTRL_ILLEGAL_EN
    logic r_ill_e;
    logic r_ill_m;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ill_e <= 1'b0;
        end else if (flushE) begin
            r_ill_e <= 1'b0;
        end else if (!stallE) begin
            r_ill_e <= w_illegal;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ill_m <= 1'b0;
        end else if (flushM) begin
            r_ill_m <= 1'b0;
        end else if (!stallM) begin
            r_ill_m <= stallE ? 1'b0 : r_ill_e;
        end
    end

    assign illegalM = r_ill_m;
`else
    assign illegalM = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Stage outputs
    // ------------------------------------------------------------------
    generate
        if (ALUCTRL_W > 4) begin : g_alu_ext
            assign alucontrolE = {{(ALUCTRL_W-4){1'b0}}, r_e.alu};
        end else begin : g_alu_exact
            assign alucontrolE = r_e.alu;
        end
    endgenerate

    assign alusrcE   = r_e.alusrc;
    assign zero_extE = r_e.zero_ext;
    assign regwriteE = r_e.regwrite;
    assign memtoregE = r_e.memtoreg;
    assign wregE     = r_e.wreg;

    assign regwriteM = r_m.regwrite;
    assign memtoregM = r_m.memtoreg;
    assign memwriteM = r_m.memwrite;
    assign linkM     = r_m.link;
    assign wregM     = r_m.wreg;

    // bne inverts the sense of the zero flag.
    assign pcsrcM    = r_m.branch & (zeroM ^ r_m.bne);

    assign regwriteW = r_w.regwrite;
    assign memtoregW = r_w.memtoreg;
    assign linkW     = r_w.link;
    assign wregW     = r_w.wreg;

endmodule
`default_nettype wire

// File: tb/tb_pipe_ctrl_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipe_ctrl_unit
//  Purpose  : Self-checking bench for pipe_ctrl_unit. An instruction-level
//             reference model (which instruction word occupies E, M and W)
//             predicts every output each cycle; directed literal checks pin
//             the model on the key scenarios; randomized traffic follows.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_ctrl_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instrD;
    logic        stallE, flushE, stallM, flushM, zeroM;
    logic        jumpD, jump_regD, branchD, alusrcE, zero_extE;
    logic [3:0]  alucontrolE;
    logic        regwriteE, regwriteM, regwriteW;
    logic        memtoregE, memtoregM, memtoregW;
    logic        memwriteM, linkM, linkW, pcsrcM, illegalM;
    logic [4:0]  wregE, wregM, wregW;

    int total = 0;
    int bad   = 0;
    bit cmp_en = 1'b0;

    pipe_ctrl_unit #(.ALUCTRL_W(4), .LINK_REG(31)) dut (
        .clk(clk), .rst(rst), .instrD(instrD),
        .stallE(stallE), .flushE(flushE), .stallM(stallM), .flushM(flushM),
        .zeroM(zeroM),
        .jumpD(jumpD), .jump_regD(jump_regD), .branchD(branchD),
        .alusrcE(alusrcE), .zero_extE(zero_extE), .alucontrolE(alucontrolE),
        .regwriteE(regwriteE), .regwriteM(regwriteM), .regwriteW(regwriteW),
        .memtoregE(memtoregE), .memtoregM(memtoregM), .memtoregW(memtoregW),
        .memwriteM(memwriteM), .linkM(linkM), .linkW(linkW),
        .wregE(wregE), .wregM(wregM), .wregW(wregW),
        .pcsrcM(pcsrcM), .illegalM(illegalM)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference decode: instruction word -> mnemonic -> expected controls
    // ------------------------------------------------------------------
    typedef enum int {
        I_UNK, I_LW, I_SW, I_BEQ, I_BNE, I_ADDI, I_ADDIU, I_ANDI, I_ORI, I_XORI,
        I_SLTI, I_LUI, I_J, I_JAL, I_ADD, I_ADDU, I_SUB, I_SUBU, I_AND, I_OR,
        I_XOR, I_NOR, I_SLT, I_JR, I_JALR
    } mn_t;

    typedef struct packed {
        bit       rw, mtr, mw, br, bne, asrc, zext, link, jmp, jreg, ill;
        bit [3:0] alu;
        bit [4:0] wreg;
    } exp_t;

    function automatic mn_t classify(input logic [31:0] ins);
        case (ins[31:26])
            6'h23: return I_LW;
            6'h2B: return I_SW;
            6'h04: return I_BEQ;
            6'h05: return I_BNE;
            6'h08: return I_ADDI;
            6'h09: return I_ADDIU;
            6'h0A: return I_SLTI;
            6'h0C: return I_ANDI;
            6'h0D: return I_ORI;
            6'h0E: return I_XORI;
            6'h0F: return I_LUI;
            6'h02: return I_J;
            6'h03: return I_JAL;
            6'h00: begin
                case (ins[5:0])
                    6'h20: return I_ADD;
                    6'h21: return I_ADDU;
                    6'h22: return I_SUB;
                    6'h23: return I_SUBU;
                    6'h24: return I_AND;
                    6'h25: return I_OR;
                    6'h26: return I_XOR;
                    6'h27: return I_NOR;
                    6'h2A: return I_SLT;
                    6'h08: return I_JR;
                    6'h09: return I_JALR;
                    default: return I_UNK;
                endcase
            end
            default: return I_UNK;
        endcase
    endfunction

    function automatic exp_t expect_of(input logic [31:0] ins);
        exp_t     x  = '0;
        bit [4:0] rt = ins[20:16];
        bit [4:0] rd = ins[15:11];
        case (classify(ins))
            I_LW:    begin x.rw = 1; x.mtr = 1; x.asrc = 1; x.alu = 4'b0010; x.wreg = rt; end
            I_SW:    begin x.mw = 1; x.asrc = 1; x.alu = 4'b0010; end
            I_BEQ:   begin x.br = 1; x.alu = 4'b0110; end
            I_BNE:   begin x.br = 1; x.bne = 1; x.alu = 4'b0110; end
            I_ADDI,
            I_ADDIU: begin x.rw = 1; x.asrc = 1; x.alu = 4'b0010; x.wreg = rt; end
            I_ANDI:  begin x.rw = 1; x.asrc = 1; x.zext = 1; x.alu = 4'b0000; x.wreg = rt; end
            I_ORI:   begin x.rw = 1; x.asrc = 1; x.zext = 1; x.alu = 4'b0001; x.wreg = rt; end
            I_XORI:  begin x.rw = 1; x.asrc = 1; x.zext = 1; x.alu = 4'b0011; x.wreg = rt; end
            I_SLTI:  begin x.rw = 1; x.asrc = 1; x.alu = 4'b0111; x.wreg = rt; end
            I_LUI:   begin x.rw = 1; x.asrc = 1; x.alu = 4'b0101; x.wreg = rt; end
            I_J:     begin x.jmp = 1; end
            I_JAL:   begin x.jmp = 1; x.rw = 1; x.link = 1; x.wreg = 5'd31; end
            I_ADD,
            I_ADDU:  begin x.rw = 1; x.alu = 4'b0010; x.wreg = rd; end
            I_SUB,
            I_SUBU:  begin x.rw = 1; x.alu = 4'b0110; x.wreg = rd; end
            I_AND:   begin x.rw = 1; x.alu = 4'b0000; x.wreg = rd; end
            I_OR:    begin x.rw = 1; x.alu = 4'b0001; x.wreg = rd; end
            I_XOR:   begin x.rw = 1; x.alu = 4'b0011; x.wreg = rd; end
            I_NOR:   begin x.rw = 1; x.alu = 4'b0100; x.wreg = rd; end
            I_SLT:   begin x.rw = 1; x.alu = 4'b0111; x.wreg = rd; end
            I_JR:    begin x.jmp = 1; x.jreg = 1; end
            I_JALR:  begin x.jmp = 1; x.jreg = 1; x.rw = 1; x.link = 1; x.wreg = rd; end
            default: x.ill = 1;
        endcase
        return x;
    endfunction

    // ------------------------------------------------------------------
    // Occupancy model: which instruction word sits in E, M and W
    // ------------------------------------------------------------------
    bit          e_v = 0, m_v = 0, w_v = 0;
    logic [31:0] e_i = '0, m_i = '0, w_i = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            e_v = 0; m_v = 0; w_v = 0;
        end else begin
            // W: an instruction held in M is not repeated into W
            w_v = stallM ? 1'b0 : m_v;
            w_i = m_i;
            // M: flush empties; hold when stalled; gap when E is held
            if (flushM) m_v = 0;
            else if (!stallM) begin
                if (stallE) m_v = 0;
                else begin m_v = e_v; m_i = e_i; end
            end
            // E
            if (flushE) e_v = 0;
            else if (!stallE) begin e_v = 1; e_i = instrD; end
        end
    end

    exp_t xd, xe, xm, xw;
    bit   x_pc, x_ill;

    always @(negedge clk) begin
        if (cmp_en) begin
            xd = expect_of(instrD);
            xe = e_v ? expect_of(e_i) : '0;
            xm = m_v ? expect_of(m_i) : '0;
            xw = w_v ? expect_of(w_i) : '0;
`ifdef CTRL_ILLEGAL_EN
            x_ill = xm.ill;
`else
            x_ill = 1'b0;
`endif
            if (xd.ill) begin xd.jmp = 0; xd.jreg = 0; end
            // beq taken on zero, bne taken on non-zero
            x_pc = (xm.br && !xm.bne && zeroM) || (xm.br && xm.bne && !zeroM);
            chk("jumpD",       jumpD,       xd.jmp);
            chk("jump_regD",   jump_regD,   xd.jreg);
            chk("branchD",     branchD,     xd.br);
            chk("alusrcE",     alusrcE,     xe.asrc);
            chk("zero_extE",   zero_extE,   xe.zext);
            chk("alucontrolE", alucontrolE, xe.alu);
            chk("regwriteE",   regwriteE,   xe.rw);
            chk("memtoregE",   memtoregE,   xe.mtr);
            chk("wregE",       wregE,       xe.wreg);
            chk("regwriteM",   regwriteM,   xm.rw);
            chk("memtoregM",   memtoregM,   xm.mtr);
            chk("memwriteM",   memwriteM,   xm.mw);
            chk("linkM",       linkM,       xm.link);
            chk("wregM",       wregM,       xm.wreg);
            chk("pcsrcM",      pcsrcM,      x_pc);
            chk("illegalM",    illegalM,    x_ill);
            chk("regwriteW",   regwriteW,   xw.rw);
            chk("memtoregW",   memtoregW,   xw.mtr);
            chk("linkW",       linkW,       xw.link);
            chk("wregW",       wregW,       xw.wreg);
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    logic [5:0] op_tab [0:12] = '{6'h23, 6'h2B, 6'h04, 6'h05, 6'h08, 6'h09,
                                  6'h0A, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h02, 6'h03};
    logic [5:0] fn_tab [0:10] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25,
                                  6'h26, 6'h27, 6'h2A, 6'h08, 6'h09};

    function automatic logic [31:0] rand_instr();
        logic [31:0] r = $urandom;
        int          k = $urandom_range(0, 25);
        if (k < 13) r[31:26] = op_tab[k];
        else if (k < 24) begin r[31:26] = 6'h00; r[5:0] = fn_tab[k-13]; end
        else if (k == 25) r = '0;
        return r;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        instrD = '0;
        repeat (n) cyc();
    endtask

    initial begin
        rst = 1'b1; instrD = '0;
        stallE = 0; flushE = 0; stallM = 0; flushM = 0; zeroM = 0;
        cmp_en = 1'b1;
        repeat (2) cyc();
        chk("rst_regwriteW", regwriteW, 0);
        chk("rst_wregE", wregE, 0);
        instrD = 32'h0C000000;          // jal: D outputs follow instrD in reset
        #1 chk("rst_jumpD_comb", jumpD, 1);
        instrD = '0;
        rst = 1'b0;

        // add $3,$1,$2
        instrD = 32'h00221820;
        cyc();
        chk("add_aluE", alucontrolE, 4'b0010);
        chk("add_wregE", wregE, 3);
        instrD = '0;
        cyc(); cyc();
        chk("add_regwriteW", regwriteW, 1);
        chk("add_wregW", wregW, 3);

        // bne / beq resolution in M
        instrD = 32'h14220000; cyc(); instrD = '0; cyc();
        zeroM = 0; #1 chk("bne_z0_pcsrc", pcsrcM, 1);
        instrD = 32'h10220000; cyc(); instrD = '0; cyc();
        zeroM = 0; #1 chk("beq_z0_pcsrc", pcsrcM, 0);
        zeroM = 1; #1 chk("beq_z1_pcsrc", pcsrcM, 1);
        zeroM = 0;
        idle(2);

        // lw $4 with a one-cycle E stall
        instrD = 32'h8C240000; cyc();
        instrD = '0; stallE = 1; cyc();
        chk("lw_held_wregE", wregE, 4);
        chk("lw_bubble_regwriteM", regwriteM, 0);
        chk("lw_bubble_wregM", wregM, 0);
        stallE = 0; cyc();
        chk("lw_wregM", wregM, 4);
        cyc();
        chk("lw_regwriteW", regwriteW, 1);
        chk("lw_wregW", wregW, 4);
        cyc();
        chk("lw_once_wregW", wregW, 0);

        // flush beats stall with sw in D
        instrD = 32'hAC240000; flushE = 1; stallE = 1; cyc();
        chk("sw_flush_regwriteE", regwriteE, 0);
        flushE = 0; stallE = 0; instrD = '0; cyc();
        chk("sw_flush_memwriteM", memwriteM, 0);
        idle(2);

        // jal, jalr $5, jr $31
        instrD = 32'h0C000000; cyc(); instrD = '0; cyc(); cyc();
        chk("jal_wregW", wregW, 31);
        chk("jal_linkW", linkW, 1);
        instrD = 32'h00202809;
        #1 chk("jalr_jump_regD", jump_regD, 1);
        cyc(); instrD = '0; cyc(); cyc();
        chk("jalr_wregW", wregW, 5);
        chk("jalr_linkW", linkW, 1);
        instrD = 32'h03E00008; cyc(); instrD = '0; cyc(); cyc();
        chk("jr_regwriteW", regwriteW, 0);

`ifdef CTRL_ILLEGAL_EN
        instrD = 32'hFC000000; cyc(); instrD = '0; cyc();
        chk("ill_illegalM", illegalM, 1);
        chk("ill_memwriteM", memwriteM, 0);
        idle(2);
`endif

        // asynchronous reset between edges
        instrD = 32'h00221820; cyc(); cyc();
        #2 rst = 1'b1;
        #1;
        chk("arst_regwriteE", regwriteE, 0);
        chk("arst_regwriteM", regwriteM, 0);
        chk("arst_wregM", wregM, 0);
        chk("arst_regwriteW", regwriteW, 0);
        #3 rst = 1'b0;
        idle(2);

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            instrD = rand_instr();
            stallE = ($urandom_range(0, 4) == 0);
            flushE = ($urandom_range(0, 9) == 0);
            stallM = ($urandom_range(0, 5) == 0);
            flushM = ($urandom_range(0, 9) == 0);
            zeroM  = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 299) == 0) begin
                #1 rst = 1'b1;
                #1 rst = 1'b0;
            end
            cyc();
        end

        stallE = 0; flushE = 0; stallM = 0; flushM = 0;
        idle(4);
        cmp_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
